product_divider: RTL and testbench

PRODUCT_DIVIDER -- requirements
Module: product_divider

---
 rtl/product_divider_if.sv | 24 ++
 rtl/product_divider.sv | 125 ++++++++++++
 tb/tb_product_divider.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/product_divider_if.sv
// Operand/result handshake bundle for product_divider.
// master = operand producer and result consumer; slave = the divider.
interface product_divider_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        dz;
    logic        ovf;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, dz, ovf
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, dz, ovf
    );
endinterface

// File: rtl/product_divider.sv
// Purpose: 16/8 unsigned restoring divider (8-bit quotient/remainder, dz/ovf flags); PRODUCT_DIVIDER_ROUND_EN enables round-half-up.
// Latency: 10 edges accept-to-out_valid (accept edge counted) for normal operands, 2 for dz/ovf; one operation in flight.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module product_divider (
    input  logic               clk,
    input  logic               rst_n,
    product_divider_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, CHECK, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [15:0] dvd_q;
    logic [7:0]  dvs_q;
    logic [7:0]  prem_q;
    logic [2:0]  cnt_q;
    logic [7:0]  quotient_q, remainder_q;
    logic        dz_q, ovf_q;
    logic        in_ready_c, out_valid_c;

    // One restoring step: low byte of dvd_q shifts dividend bits out and quotient bits in.
    logic [8:0] trial;
    logic       fits;
    logic [7:0] diff, prem_step, q_step;

    assign trial     = {prem_q, dvd_q[7]};
    assign fits      = trial >= {1'b0, dvs_q};
    assign diff      = trial[7:0] - dvs_q;
    assign prem_step = fits ? diff : trial[7:0];
    assign q_step    = {dvd_q[6:0], fits};

    logic last_step, is_dz, is_ovf;
    assign last_step = (cnt_q == 3'd7);
    assign is_dz     = (dvs_q == 8'd0);
    assign is_ovf    = (dvd_q[15:8] >= dvs_q);

`ifdef PRODUCT_DIVIDER_ROUND_EN
    logic round_up, q_sat;
    assign round_up = {prem_step, 1'b0} >= {1'b0, dvs_q};
    assign q_sat    = round_up && (q_step == 8'hFF);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_nxt = CHECK;
            end
            CHECK:   state_nxt = (is_dz || is_ovf) ? DONE : RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q       <= '0;
            dvs_q       <= '0;
            prem_q      <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    dvd_q <= bus.dividend;
                    dvs_q <= bus.divisor;
                end
                CHECK: begin
                    if (is_dz) begin
                        quotient_q  <= 8'hFF;
                        remainder_q <= dvd_q[7:0];
                        dz_q        <= 1'b1;
                        ovf_q       <= 1'b0;
                    end else if (is_ovf) begin
                        quotient_q  <= 8'hFF;
                        remainder_q <= 8'h00;
                        dz_q        <= 1'b0;
                        ovf_q       <= 1'b1;
                    end else begin
                        prem_q <= dvd_q[15:8];
                        cnt_q  <= 3'd0;
                    end
                end
                RUN: begin
                    prem_q     <= prem_step;
                    dvd_q[7:0] <= q_step;
                    cnt_q      <= cnt_q + 3'd1;
                    if (last_step) begin
                        remainder_q <= prem_step;
                        dz_q        <= 1'b0;
`ifdef PRODUCT_DIVIDER_ROUND_EN
                        quotient_q  <= q_sat ? 8'hFF : q_step + {7'd0, round_up};
                        ovf_q       <= q_sat;
`else
                        quotient_q  <= q_step;
                        ovf_q       <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.dz        = dz_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_product_divider.sv
// Directed-vector bench for product_divider; expectations follow PRODUCT_DIVIDER_ROUND_EN.
// Latency is counted in rising edges, the accept edge being edge 1.
module tb_product_divider;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    product_divider_if bus ();

    product_divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one operation, measure latency, check fields, optionally hold out_ready low.
    task automatic run_op(input string tag, input logic [15:0] dvd, input logic [7:0] dvs,
                          input logic [7:0] eq, input logic [7:0] er, input logic edz,
                          input logic eovf, input int elat, input int hold);
        int lat;
        @(negedge clk);
        chk({tag, ".in_ready"}, bus.in_ready, 1);
        bus.dividend = dvd;
        bus.divisor  = dvs;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({tag, ".lat"}, lat, elat);
        chk({tag, ".q"}, bus.quotient, eq);
        chk({tag, ".r"}, bus.remainder, er);
        chk({tag, ".dz"}, bus.dz, edz);
        chk({tag, ".ovf"}, bus.ovf, eovf);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = (i == 2);
            bus.dividend = 16'h0005;
            bus.divisor  = 8'd1;
            @(posedge clk);
            @(negedge clk);
            chk({tag, ".hold_vld"}, bus.out_valid, 1);
            chk({tag, ".hold_rdy"}, bus.in_ready, 0);
            chk({tag, ".hold_q"}, bus.quotient, eq);
            chk({tag, ".hold_r"}, bus.remainder, er);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, ".ret_vld"}, bus.out_valid, 0);
        chk({tag, ".ret_rdy"}, bus.in_ready, 1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #12;
        chk("rst.out_valid", bus.out_valid, 0);
        chk("rst.q", bus.quotient, 0);
        chk("rst.r", bus.remainder, 0);
        chk("rst.dz", bus.dz, 0);
        chk("rst.ovf", bus.ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst.in_ready", bus.in_ready, 1);

        run_op("v20000_200", 16'h4E20, 8'd200, 8'd100, 8'd0, 1'b0, 1'b0, 10, 0);
        run_op("dz", 16'h04D2, 8'd0, 8'hFF, 8'hD2, 1'b1, 1'b0, 2, 0);
        run_op("ovf", 16'h1200, 8'h10, 8'hFF, 8'h00, 1'b0, 1'b1, 2, 0);
        run_op("ovf_eq", 16'hFF00, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 2, 0);
        run_op("zero", 16'd0, 8'd5, 8'd0, 8'd0, 1'b0, 1'b0, 10, 0);
        run_op("ff_ff", 16'h00FF, 8'hFF, 8'd1, 8'd0, 1'b0, 1'b0, 10, 0);
`ifdef PRODUCT_DIVIDER_ROUND_EN
        run_op("v20_8", 16'd20, 8'd8, 8'd3, 8'd4, 1'b0, 1'b0, 10, 0);
        run_op("v1000_7", 16'd1000, 8'd7, 8'd143, 8'd6, 1'b0, 1'b0, 10, 0);
        run_op("sat511_2", 16'h01FF, 8'd2, 8'hFF, 8'd1, 1'b0, 1'b1, 10, 0);
        run_op("max", 16'hFEFF, 8'hFF, 8'hFF, 8'd254, 1'b0, 1'b1, 10, 0);
`else
        run_op("v20_8", 16'd20, 8'd8, 8'd2, 8'd4, 1'b0, 1'b0, 10, 0);
        run_op("v1000_7", 16'd1000, 8'd7, 8'd142, 8'd6, 1'b0, 1'b0, 10, 0);
        run_op("v511_2", 16'h01FF, 8'd2, 8'hFF, 8'd1, 1'b0, 1'b0, 10, 0);
        run_op("max", 16'hFEFF, 8'hFF, 8'hFF, 8'd254, 1'b0, 1'b0, 10, 0);
`endif

        // Backpressure: 5 held cycles with a pulsed in_valid that must be dropped.
        run_op("bp", 16'h4E20, 8'd200, 8'd100, 8'd0, 1'b0, 1'b0, 10, 5);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid) break;
        end
        chk("bp.no_ghost", bus.out_valid, 0);

        // Reset in the 4th RUN cycle aborts the operation.
        @(negedge clk);
        bus.dividend = 16'd1000;
        bus.divisor  = 8'd7;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort.out_valid", bus.out_valid, 0);
        chk("abort.in_ready", bus.in_ready, 1);
        chk("abort.q", bus.quotient, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid) break;
        end
        chk("abort.no_result", bus.out_valid, 0);
        run_op("after_abort", 16'h4E20, 8'd200, 8'd100, 8'd0, 1'b0, 1'b0, 10, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
